// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer and msip software interrupt
// behind a 32-bit Wishbone classic slave port.
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_addr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  localparam logic [15:0] PreMax = 16'(TICK_DIV - 1);

  logic [15:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        mtip_q;

  logic        tick;
  logic        access;
  logic        wr;
  reg_sel_e    reg_sel;
  logic [31:0] rdata;
  logic [31:0] wmask;
  logic [31:0] wmerge;
  logic        unused_addr;

  assign unused_addr = ^wb_addr_i[1:0];

  assign tick   = (pre_q == PreMax);
  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr     = access & wb_we_i;

  always_comb begin
    reg_sel = REG_NONE;
    case (wb_addr_i[15:2])
      14'h0000: reg_sel = REG_MSIP;
      14'h1000: reg_sel = REG_CMP_LO;
      14'h1001: reg_sel = REG_CMP_HI;
      14'h2FFE: reg_sel = REG_TIME_LO;
      14'h2FFF: reg_sel = REG_TIME_HI;
      default:  reg_sel = REG_NONE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_MSIP:    rdata = {31'd0, msip_q};
      REG_CMP_LO:  rdata = mtimecmp_q[31:0];
      REG_CMP_HI:  rdata = mtimecmp_q[63:32];
      REG_TIME_LO: rdata = mtime_q[31:0];
      REG_TIME_HI: rdata = mtime_q[63:32];
      default:     rdata = '0;
    endcase
  end

  // Byte merge against the addressed register's current word (the read-mux value).
  assign wmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmerge = (rdata & ~wmask) | (wb_dat_i & wmask);

  always_comb begin
    pre_d      = tick ? '0 : pre_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A bus write to an mtime half overrides that edge's increment entirely.
    if (wr) begin
      case (reg_sel)
        REG_MSIP:    msip_d = wmerge[0];
        REG_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], wmerge};
        REG_CMP_HI:  mtimecmp_d = {wmerge, mtimecmp_q[31:0]};
        REG_TIME_LO: mtime_d = {mtime_q[63:32], wmerge};
        REG_TIME_HI: mtime_d = {wmerge, mtime_q[31:0]};
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pre_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      mtip_q     <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ack_q      <= access;
      if (access) dat_q <= rdata;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign xint_mtip_o = mtip_q;
  assign xint_msip_o = msip_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: instance A runs TICK_DIV=1, instance B runs TICK_DIV=4.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cyc_a = 1'b0, cyc_b = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, mtip_a, mtip_b, msip_a, msip_b;

  int checks = 0;
  int failures = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  // Edge index since reset release: first edge with rst_i=1 is index 1.
  always @(posedge clk) begin
    if (!rst_i) cnt <= 0;
    else        cnt <= cnt + 1;
  end

  clint #(.TICK_DIV(1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_a),
    .wb_ack_o(ack_a), .xint_mtip_o(mtip_a), .xint_msip_o(msip_a)
  );

  clint #(.TICK_DIV(4)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_b),
    .wb_ack_o(ack_b), .xint_mtip_o(mtip_b), .xint_msip_o(msip_b)
  );

  // One access: E0 is the first posedge after the drive; returns just after E1.
  task automatic bus(input bit b, input bit w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output int e0,
                     output logic mtip_at, output logic msip_at);
    @(negedge clk);
    cyc_a = !b; cyc_b = b; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    rd      = b ? dat_b : dat_a;
    e0      = cnt;
    mtip_at = b ? mtip_b : mtip_a;
    msip_at = b ? msip_b : msip_a;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd32(input bit b, input logic [15:0] a, output logic [31:0] rd, output int e0);
    logic mt, ms;
    bus(b, 1'b0, a, 32'h0, 4'hF, rd, e0, mt, ms);
  endtask

  task automatic wr32(input bit b, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int e0);
    logic [31:0] rd;
    logic mt, ms;
    bus(b, 1'b1, a, d, s, rd, e0, mt, ms);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int e;
    logic bad;
    // write to msip while reset is held must be discarded
    @(negedge clk);
    rst_i = 1'b0; cyc_a = 1'b1; cyc_b = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 16'h0000; wdat = 32'h1; sel = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack_a, ack_b, mtip_a, mtip_b, msip_a, msip_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b%b mtip=%b%b msip=%b%b, want all 0",
               ack_a, ack_b, mtip_a, mtip_b, msip_a, msip_b);
    end
    checks++;
    if (dat_a !== 32'h0 || dat_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_dat: got %h/%h, want 0", dat_a, dat_b);
    end
    @(negedge clk);
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0; rst_i = 1'b1;

    rd32(0, 16'h4000, r, e);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp_lo_reset: got %h, want ffffffff", r); end
    rd32(0, 16'h4004, r, e);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp_hi_reset: got %h, want ffffffff", r); end
    rd32(0, 16'h0000, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL msip_reset: got %h, want 0", r); end

    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bad = bad | mtip_a | msip_a | mtip_b | msip_b;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL irq_quiet: got %b, want 0", bad); end

    rd32(0, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'(e - 1)) begin failures++; $display("FAIL mtime_div1: got %0d, want %0d", r, e - 1); end
    rd32(1, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'((e - 1) / 4)) begin failures++; $display("FAIL mtime_div4: got %0d, want %0d", r, (e - 1) / 4); end
  endtask

  task automatic test_tick_div4;
    logic [31:0] r;
    int e, n;
    int t[3];
    logic [63:0] prev;
    @(negedge clk); rst_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b1;
    repeat (40) @(negedge clk);
    rd32(1, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'd10) begin failures++; $display("FAIL div4_after40: got %0d, want 10 (E0=%0d)", r, e); end

    n = 0;
    prev = dut_b.mtime_q;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      if (dut_b.mtime_q !== prev) begin
        t[n] = cnt;
        n++;
        prev = dut_b.mtime_q;
      end
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL div4_period: saw %0d increments in 30 cycles, want 3", n);
    end else if (t[1] - t[0] != 4 || t[2] - t[1] != 4 || t[0] % 4 != 0) begin
      failures++;
      $display("FAIL div4_period: increments at edges %0d,%0d,%0d, want spacing 4 on multiples of 4",
               t[0], t[1], t[2]);
    end
  endtask

  task automatic test_compare;
    logic [31:0] r;
    int e, ew, rise;
    logic mt, ms;
    wr32(0, 16'hBFFC, 32'h0, 4'hF, e);
    wr32(0, 16'hBFF8, 32'h0, 4'hF, ew);
    wr32(0, 16'h4004, 32'h0, 4'hF, e);
    wr32(0, 16'h4000, 32'h20, 4'hF, e);
    rise = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (mtip_a === 1'b1) begin rise = cnt; break; end
    end
    checks++;
    if (rise != ew + 33) begin failures++; $display("FAIL mtip_rise: got edge %0d, want %0d", rise, ew + 33); end

    checks++;
    if (mtip_a !== 1'b1) begin failures++; $display("FAIL mtip_high: got %b, want 1", mtip_a); end
    bus(0, 1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, r, e, mt, ms);
    checks++;
    if (mt !== 1'b1) begin failures++; $display("FAIL mtip_at_ack: got %b, want 1", mt); end
    checks++;
    if (mtip_a !== 1'b0) begin failures++; $display("FAIL mtip_drop: got %b, want 0", mtip_a); end
    wr32(0, 16'h4004, 32'hFFFF_FFFF, 4'hF, e);
    checks++;
    if (mtip_a !== 1'b0) begin failures++; $display("FAIL mtip_stay_low: got %b, want 0", mtip_a); end
  endtask

  task automatic test_msip_sel;
    logic [31:0] r;
    int e;
    logic mt, ms;
    bus(0, 1'b1, 16'h0000, 32'h1, 4'b0010, r, e, mt, ms);
    checks++;
    if (ms !== 1'b0 || msip_a !== 1'b0) begin failures++; $display("FAIL msip_sel1: got %b/%b, want 0", ms, msip_a); end
    bus(0, 1'b1, 16'h0000, 32'h1, 4'b0001, r, e, mt, ms);
    checks++;
    if (ms !== 1'b1) begin failures++; $display("FAIL msip_rise_with_ack: got %b, want 1", ms); end
    wr32(0, 16'h0000, 32'hFFFF_FFFF, 4'hF, e);
    rd32(0, 16'h0000, r, e);
    checks++;
    if (r !== 32'h1) begin failures++; $display("FAIL msip_readback: got %h, want 00000001", r); end
    bus(0, 1'b1, 16'h0000, 32'h0, 4'b0001, r, e, mt, ms);
    checks++;
    if (ms !== 1'b0) begin failures++; $display("FAIL msip_fall: got %b, want 0", ms); end
  endtask

  task automatic test_wrap_collision;
    logic [31:0] r;
    int e, el, e5, rise;
    logic mt, ms;
    wr32(0, 16'h4000, 32'h10, 4'hF, e);
    wr32(0, 16'h4004, 32'h0, 4'hF, e);
    wr32(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, e);
    bus(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, r, el, mt, ms);
    checks++;
    if (mtip_a !== 1'b1) begin failures++; $display("FAIL wrap_mtip_max: got %b, want 1", mtip_a); end
    @(posedge clk); #1;
    checks++;
    if (mtip_a !== 1'b0) begin failures++; $display("FAIL wrap_mtip_zero: got %b, want 0", mtip_a); end
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mtip_a === 1'b1) begin rise = cnt; break; end
    end
    checks++;
    if (rise != el + 18) begin failures++; $display("FAIL wrap_mtip_rise: got edge %0d, want %0d", rise, el + 18); end
    rd32(0, 16'hBFFC, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL wrap_hi: got %h, want 0", r); end
    rd32(0, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'(e - el - 2)) begin failures++; $display("FAIL wrap_lo: got %0d, want %0d", r, e - el - 2); end

    wr32(0, 16'hBFF8, 32'h5, 4'hF, e5);
    rd32(0, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'(e - e5 + 4)) begin failures++; $display("FAIL collide_a_lo: got %0d, want %0d", r, e - e5 + 4); end
    rd32(0, 16'hBFFC, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL collide_a_hi: got %h, want 0", r); end

    // instance B: land the write exactly on a tick edge (index multiple of 4)
    for (int i = 0; i < 8 && (cnt % 4) != 2; i++) @(negedge clk);
    wr32(1, 16'hBFF8, 32'h5, 4'hF, e5);
    rd32(1, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'(5 + (e - 1) / 4 - e5 / 4) || e5 % 4 != 0) begin
      failures++;
      $display("FAIL collide_b_first: got %0d at write edge %0d, want %0d", r, e5, 5 + (e - 1) / 4 - e5 / 4);
    end
    repeat (5) @(negedge clk);
    rd32(1, 16'hBFF8, r, e);
    checks++;
    if (r !== 32'(5 + (e - 1) / 4 - e5 / 4)) begin
      failures++;
      $display("FAIL collide_b_later: got %0d, want %0d", r, 5 + (e - 1) / 4 - e5 / 4);
    end
  endtask

  task automatic test_handshake_unmapped;
    logic [31:0] r;
    int e;
    @(negedge clk);
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; addr = 16'h1234; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack_a !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL ack_pattern[%0d]: got %b, want %b", i, ack_a, (i % 2) == 0);
      end
      if (ack_a === 1'b1) begin
        checks++;
        if (dat_a !== 32'h0) begin failures++; $display("FAIL unmapped_rd[%0d]: got %h, want 0", i, dat_a); end
      end
    end
    @(negedge clk);
    cyc_a = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    wr32(0, 16'h1234, 32'hDEAD_BEEF, 4'hF, e);
    rd32(0, 16'h1234, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL unmapped_after_wr: got %h, want 0", r); end
    rd32(0, 16'h0000, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL unmapped_msip: got %h, want 0", r); end
    rd32(0, 16'h4000, r, e);
    checks++;
    if (r !== 32'h10) begin failures++; $display("FAIL unmapped_cmp_lo: got %h, want 00000010", r); end
    rd32(0, 16'h4004, r, e);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL unmapped_cmp_hi: got %h, want 0", r); end

    wr32(0, 16'h4000, 32'hAABB_CCDD, 4'b1010, e);
    rd32(0, 16'h4000, r, e);
    checks++;
    if (r !== 32'hAA00_CC10) begin failures++; $display("FAIL cmp_byte_merge: got %h, want aa00cc10", r); end
  endtask

  initial begin
    test_reset;
    test_tick_div4;
    test_compare;
    test_msip_sel;
    test_wrap_collision;
    test_handshake_unmapped;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
